// File: rtl/bp_me_wormhole_to_stream.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_to_stream
//
// Receive-side wormhole-to-BedRock-stream converter. Collects the multi-flit
// wormhole header, strips the cord/len/cid routing fields and presents the
// BedRock protocol header as a single header beat. The remaining data flits
// are then passed straight through as BedRock burst data beats.
//
// Ports:
//   clk_i             clock
//   reset_n_i         asynchronous active-low reset
//   link_data_i       incoming wormhole flit
//   link_v_i          flit valid
//   link_ready_and_o  flit accepted when link_v_i & link_ready_and_o
//   pr_hdr_o          decoded protocol header, stable for the whole message
//   pr_data_o         data beat
//   pr_v_o            beat valid
//   pr_ready_and_i    consumer ready
//   pr_hdr_v_o        current beat is the header beat
//   pr_last_o         current beat is the final beat of the message
// ---------------------------------------------------------------------------
module bp_me_wormhole_to_stream #(
  parameter int flit_width_p       = 64,
  parameter int cord_width_p       = 8,
  parameter int len_width_p        = 4,
  parameter int cid_width_p        = 2,
  parameter int pr_hdr_width_p     = 100,
  parameter int pr_data_width_p    = 64,
  parameter int wh_hdr_width_p     = cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p,
  parameter int wh_pr_hdr_offset_p = cord_width_p + len_width_p + cid_width_p,
  parameter int wh_len_offset_p    = cord_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [flit_width_p-1:0]    link_data_i,
  input  logic                       link_v_i,
  output logic                       link_ready_and_o,

  output logic [pr_hdr_width_p-1:0]  pr_hdr_o,
  output logic [pr_data_width_p-1:0] pr_data_o,
  output logic                       pr_v_o,
  input  logic                       pr_ready_and_i,
  output logic                       pr_hdr_v_o,
  output logic                       pr_last_o
);

  localparam int hdr_len_lp        = (wh_hdr_width_p + flit_width_p - 1) / flit_width_p;
  localparam int hdr_bits_lp       = hdr_len_lp * flit_width_p;
  localparam int flit_cnt_width_lp = (hdr_len_lp > 1) ? $clog2(hdr_len_lp) : 1;

  localparam logic [flit_cnt_width_lp-1:0] last_flit_lp  = flit_cnt_width_lp'(hdr_len_lp - 1);
  // Header flits beyond the first are counted in len but are not data beats.
  localparam logic [len_width_p-1:0]       hdr_extra_lp  = len_width_p'(hdr_len_lp - 1);
  localparam logic [len_width_p-1:0]       one_lp        = len_width_p'(1);

  if (pr_data_width_p != flit_width_p) begin : g_width_check
    $error("pr_data_width_p must equal flit_width_p");
  end
  if ((flit_width_p & (flit_width_p - 1)) != 0) begin : g_pow2_check
    $error("flit_width_p must be a power of 2");
  end

  typedef enum logic [1:0] {
    e_hdr_collect,
    e_hdr_out,
    e_data
  } state_e;

  state_e                                state_q, state_d;
  logic [flit_cnt_width_lp-1:0]          flit_cnt_q, flit_cnt_d;
  logic [len_width_p-1:0]                data_cnt_q, data_cnt_d;
  // Clears asynchronously with reset so the link is refused while in reset
  // and during the cycle of release; set by the first clock edge after.
  logic                                  ready_q;

  logic [hdr_len_lp-1:0][flit_width_p-1:0] hdr_q, hdr_d;
  logic [hdr_bits_lp-1:0]                  hdr_flat;
  logic [hdr_bits_lp-1:0]                  hdr_next_flat;
  logic                                    hdr_we;
  logic                                    hdr_done;
  logic [len_width_p-1:0]                  len_next;

  // Header image including the flit being accepted this cycle, so len is
  // available when the final header flit arrives.
  always_comb begin
    hdr_d             = hdr_q;
    hdr_d[flit_cnt_q] = link_data_i;
  end

  assign hdr_flat      = hdr_q;
  assign hdr_next_flat = hdr_d;
  assign len_next      = hdr_next_flat[wh_len_offset_p +: len_width_p];

  // Cord, cid and padding bits are intentionally discarded.
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^hdr_flat;

  assign pr_hdr_o  = hdr_flat[wh_pr_hdr_offset_p +: pr_hdr_width_p];
  assign pr_data_o = link_data_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_hdr_collect;
      flit_cnt_q <= '0;
      data_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      data_cnt_q <= data_cnt_d;
      ready_q    <= 1'b1;
    end
  end

  // NOTE: the header store has no reset; every slot is rewritten before it
  // is read, so a reset would only add fan-out on the reset net.
  always_ff @(posedge clk_i) begin
    if (hdr_we) begin
      hdr_q <= hdr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    flit_cnt_d       = flit_cnt_q;
    data_cnt_d       = data_cnt_q;
    hdr_we           = 1'b0;
    hdr_done         = 1'b0;
    link_ready_and_o = 1'b0;
    pr_v_o           = 1'b0;
    pr_hdr_v_o       = 1'b0;
    pr_last_o        = 1'b0;

    unique case (state_q)
      e_hdr_collect: begin
        link_ready_and_o = ready_q;
        if (link_v_i && ready_q) begin
          hdr_we = 1'b1;
          if (flit_cnt_q == last_flit_lp) begin
            hdr_done   = 1'b1;
            flit_cnt_d = '0;
            data_cnt_d = len_next - hdr_extra_lp;
            state_d    = e_hdr_out;
          end else begin
            flit_cnt_d = flit_cnt_q + flit_cnt_width_lp'(1);
          end
        end
      end

      e_hdr_out: begin
        pr_v_o     = 1'b1;
        pr_hdr_v_o = 1'b1;
        pr_last_o  = (data_cnt_q == '0);
        if (pr_ready_and_i) begin
          state_d = (data_cnt_q != '0) ? e_data : e_hdr_collect;
        end
      end

      e_data: begin
        // Zero-latency pass-through: the consumer stalls the link directly.
        pr_v_o           = link_v_i;
        link_ready_and_o = pr_ready_and_i;
        pr_last_o        = (data_cnt_q == one_lp);
        if (link_v_i && pr_ready_and_i) begin
          data_cnt_d = data_cnt_q - one_lp;
          if (data_cnt_q == one_lp) begin
            state_d = e_hdr_collect;
          end
        end
      end

      default: begin
        state_d = e_hdr_collect;
      end
    endcase
  end

  // A packet shorter than its own header is malformed.
  a_legal_len: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    hdr_done |-> (len_next >= hdr_extra_lp))
    else $error("wormhole packet len shorter than header");

endmodule

// File: tb/tb_bp_me_wormhole_to_stream.sv
// ---------------------------------------------------------------------------
// tb_bp_me_wormhole_to_stream
//
// Directed bench for bp_me_wormhole_to_stream at default parameters
// (two header flits). Inputs are driven on the falling edge and outputs are
// checked 1 time unit later, so transfers happen on the following rising
// edge. Wormhole headers are built as {pad, pr_hdr, cid, len, cord}.
// ---------------------------------------------------------------------------
module tb_bp_me_wormhole_to_stream;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [63:0]  link_data_i;
  logic         link_v_i;
  logic         link_ready_and_o;
  logic [99:0]  pr_hdr_o;
  logic [63:0]  pr_data_o;
  logic         pr_v_o;
  logic         pr_ready_and_i;
  logic         pr_hdr_v_o;
  logic         pr_last_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  bp_me_wormhole_to_stream dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .link_data_i      (link_data_i),
    .link_v_i         (link_v_i),
    .link_ready_and_o (link_ready_and_o),
    .pr_hdr_o         (pr_hdr_o),
    .pr_data_o        (pr_data_o),
    .pr_v_o           (pr_v_o),
    .pr_ready_and_i   (pr_ready_and_i),
    .pr_hdr_v_o       (pr_hdr_v_o),
    .pr_last_o        (pr_last_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Padding bits are set to ones to show they are ignored.
  function automatic logic [127:0] make_hdr(input logic [7:0] cord, input logic [3:0] len,
                                            input logic [1:0] cid, input logic [99:0] prh);
    return {14'h3fff, prh, cid, len, cord};
  endfunction

  task automatic push_flit(input logic [63:0] d, input string tag);
    @(negedge clk_i);
    link_v_i = 1'b1; link_data_i = d; pr_ready_and_i = 1'b1;
    #1;
    check({tag, " link_ready"}, 128'(link_ready_and_o), 128'd1);
    check({tag, " pr_v"},       128'(pr_v_o),           128'd0);
  endtask

  task automatic send_hdr(input logic [127:0] w, input string tag);
    push_flit(w[63:0],   {tag, " f0"});
    push_flit(w[127:64], {tag, " f1"});
  endtask

  // Header beat, stalled for 'stall' cycles before the consumer takes it.
  task automatic expect_hdr(input logic [99:0] h, input logic last, input logic nv,
                            input logic [63:0] nd, input int stall, input string tag);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk_i);
      link_v_i = nv; link_data_i = nd; pr_ready_and_i = (i == stall);
      #1;
      check({tag, " hdr pr_v"},   128'(pr_v_o),           128'd1);
      check({tag, " hdr_v"},      128'(pr_hdr_v_o),       128'd1);
      check({tag, " hdr value"},  128'(pr_hdr_o),         128'(h));
      check({tag, " hdr last"},   128'(pr_last_o),        128'(last));
      check({tag, " hdr ready"},  128'(link_ready_and_o), 128'd0);
    end
  endtask

  task automatic data_beat(input logic [63:0] d, input logic [99:0] h, input logic last,
                           input int stall, input string tag);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk_i);
      link_v_i = 1'b1; link_data_i = d; pr_ready_and_i = (i == stall);
      #1;
      check({tag, " pr_v"},       128'(pr_v_o),           128'd1);
      check({tag, " hdr_v"},      128'(pr_hdr_v_o),       128'd0);
      check({tag, " data"},       128'(pr_data_o),        128'(d));
      check({tag, " last"},       128'(pr_last_o),        128'(last));
      check({tag, " ready"},      128'(link_ready_and_o), 128'(i == stall));
      check({tag, " hdr stable"}, 128'(pr_hdr_o),         128'(h));
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk_i);
    link_v_i = 1'b0; pr_ready_and_i = 1'b1;
    #1;
    check({tag, " idle ready"}, 128'(link_ready_and_o), 128'd1);
    check({tag, " idle pr_v"},  128'(pr_v_o),           128'd0);
  endtask

  logic [99:0] h1, h2, h3, h4, h5, h6;

  initial begin
    h1 = 100'h1_2345_6789_ABCD_EF01_2345_6789;
    h2 = 100'hF_EDCB_A987_6543_2100_1122_3344;
    h3 = 100'h5_5555_AAAA_5555_AAAA_0F0F_F0F0;
    h4 = 100'h0_0000_0000_0000_0000_0000_0001;
    h5 = 100'h8_0000_0000_0000_0000_0000_0000;
    h6 = {$urandom(), $urandom(), $urandom(), 4'($urandom())};

    reset_n_i = 1'b0; link_v_i = 1'b0; link_data_i = '0; pr_ready_and_i = 1'b0;
    #1;
    check("reset link_ready", 128'(link_ready_and_o), 128'd0);
    check("reset pr_v",       128'(pr_v_o),           128'd0);
    check("reset hdr_v",      128'(pr_hdr_v_o),       128'd0);
    check("reset last",       128'(pr_last_o),        128'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Header-only packet.
    send_hdr(make_hdr(8'h01, 4'd1, 2'd0, h1), "p1");
    expect_hdr(h1, 1'b1, 1'b0, 64'h0, 0, "p1");
    idle_check("p1");

    // Four data beats, no stalls.
    send_hdr(make_hdr(8'h02, 4'd5, 2'd1, h2), "p2");
    expect_hdr(h2, 1'b0, 1'b0, 64'h0, 0, "p2");
    for (int i = 0; i < 4; i++) begin
      data_beat(64'h10 + 64'(i), h2, (i == 3), 0, "p2 data");
    end
    idle_check("p2");

    // Backpressure on the header beat and on beat 2.
    send_hdr(make_hdr(8'h03, 4'd5, 2'd2, h3), "p3");
    expect_hdr(h3, 1'b0, 1'b1, 64'h30, 5, "p3");
    data_beat(64'h30, h3, 1'b0, 0, "p3 d0");
    data_beat(64'h31, h3, 1'b0, 5, "p3 d1");
    data_beat(64'h32, h3, 1'b0, 0, "p3 d2");
    data_beat(64'h33, h3, 1'b1, 0, "p3 d3");
    idle_check("p3");

    // Back-to-back: len=3 then len=1 with link_v_i held high.
    send_hdr(make_hdr(8'h04, 4'd3, 2'd0, h4), "p4");
    expect_hdr(h4, 1'b0, 1'b1, 64'h40, 0, "p4");
    data_beat(64'h40, h4, 1'b0, 0, "p4 d0");
    data_beat(64'h41, h4, 1'b1, 0, "p4 d1");
    send_hdr(make_hdr(8'h05, 4'd1, 2'd1, h5), "p5");
    expect_hdr(h5, 1'b1, 1'b0, 64'h0, 0, "p5");
    idle_check("p5");

    // Asynchronous reset in the middle of the data phase.
    send_hdr(make_hdr(8'h06, 4'd5, 2'd0, h3), "p6");
    expect_hdr(h3, 1'b0, 1'b1, 64'h60, 0, "p6");
    data_beat(64'h60, h3, 1'b0, 0, "p6 d0");
    data_beat(64'h61, h3, 1'b0, 0, "p6 d1");
    @(negedge clk_i);
    link_v_i = 1'b1; link_data_i = 64'h62; pr_ready_and_i = 1'b1;
    #1;
    check("p6 pre-reset pr_v", 128'(pr_v_o), 128'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async rst pr_v",       128'(pr_v_o),           128'd0);
    check("async rst link_ready", 128'(link_ready_and_o), 128'd0);
    check("async rst hdr_v",      128'(pr_hdr_v_o),       128'd0);
    check("async rst last",       128'(pr_last_o),        128'd0);
    @(negedge clk_i);
    link_v_i = 1'b0;
    #1;
    check("in rst link_ready", 128'(link_ready_and_o), 128'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    send_hdr(make_hdr(8'h07, 4'd1, 2'd2, h2), "p7");
    expect_hdr(h2, 1'b1, 1'b0, 64'h0, 0, "p7");
    idle_check("p7");

    // Field stripping with non-zero cord and cid and a random protocol header.
    send_hdr(make_hdr(8'hA5, 4'd1, 2'd3, h6), "p8");
    expect_hdr(h6, 1'b1, 1'b0, 64'h0, 0, "p8");
    idle_check("p8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
